// File: rtl/final_bits_flusher.sv
// final_bits_flusher
//
// Sequential end-of-frame flusher for the encoder pipeline. A flush request
// captures the final low/cnt pair. The block applies end-of-frame rounding, or
// passes low through untouched in raw mode. It then serialises between 1 and
// MAX_WORDS words toward carry propagation over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   flush request
//   in_ready   block idle, request accepted when in_valid & in_ready
//   in_low     final low value (LOW_WIDTH bits)
//   in_cnt     final bit count, unsigned (D_SIZE bits)
//   in_mode    0 = rounded termination, 1 = raw (e = low)
//   out_valid  out_word holds a valid word
//   out_ready  downstream accepts the current word
//   out_word   emitted word (OUTPUT_BITSTREAM_WIDTH bits)
//   out_index  0-based index of the current word
//   out_last   current word is the final word of this flush
//   out_error  one-cycle pulse, request rejected because in_cnt is out of range
//
// All outputs come straight from flops. No combinational path exists from
// in_valid or out_ready to any output.

module final_bits_flusher #(
  parameter int OUTPUT_BITSTREAM_WIDTH = 16,
  parameter int D_SIZE                 = 5,
  parameter int LOW_WIDTH              = 24,
  parameter int ROUND_BITS             = 14,
  parameter int MAX_WORDS              = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LOW_WIDTH-1:0]              in_low,
  input  logic [D_SIZE-1:0]                 in_cnt,
  input  logic                              in_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_word,
  output logic [1:0]                        out_index,
  output logic                              out_last,
  output logic                              out_error
);

  // e carries one extra bit so the rounding carry out of low is kept.
  localparam int EW = LOW_WIDTH + 1;

  // Rounding mask M and the bit just above it (M + 1).
  localparam logic [EW-1:0] ROUND_MASK = {{(EW - ROUND_BITS){1'b0}}, {ROUND_BITS{1'b1}}};
  localparam logic [EW-1:0] ROUND_BIT  = ROUND_MASK + EW'(1);

  // Largest cnt that still leaves word 0 with a non-negative shift for
  // every word.
  localparam logic [D_SIZE-1:0] CNT_MAX = D_SIZE'(LOW_WIDTH - 8);

  // Highest legal word index. It clamps the word count, so a wide D_SIZE
  // can never push out_index past the words that exist.
  localparam logic [D_SIZE-4:0] MAX_IDX_WIDE = (D_SIZE - 3)'(MAX_WORDS - 1);
  localparam logic [1:0]        MAX_IDX      = 2'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [LOW_WIDTH-1:0] low_q;
  logic [D_SIZE-1:0]    cnt_q;
  logic                 mode_q;
  logic [EW-1:0]        e_q;

  // Combinational helpers
  logic [EW-1:0]        e_calc;
  logic [D_SIZE-4:0]    words_m1;
  logic [1:0]           last_idx;
  logic                 accept;
  logic                 cnt_bad;
  logic                 handshake;
  logic                 load_in;
  logic                 load_e;

  // Next values for the registered outputs
  logic                              in_ready_d;
  logic                              out_valid_d;
  logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_word_d;
  logic [1:0]                        out_index_d;
  logic                              out_last_d;
  logic                              out_error_d;

  // Word i is e shifted right by cnt + 7 - 8i. Word 0 keeps everything above
  // the shift, up to the output width, because it carries the rounding carry.
  // Later words keep only one byte.
  function automatic logic [OUTPUT_BITSTREAM_WIDTH-1:0] word_at(
    input logic [EW-1:0]     e,
    input logic [D_SIZE-1:0] c,
    input logic [1:0]        i
  );
    logic [D_SIZE+1:0] sh;
    logic [EW-1:0]     s;
    sh = (D_SIZE + 2)'(c) + (D_SIZE + 2)'(7) - (D_SIZE + 2)'({i, 3'b000});
    s  = e >> sh;
    if (i == 2'd0) begin
      return OUTPUT_BITSTREAM_WIDTH'(s);
    end
    return OUTPUT_BITSTREAM_WIDTH'(s[7:0]);
  endfunction

  // The terminated value. Rounded mode rounds low up to the next multiple of
  // M+1 and then forces the M+1 bit on. The extra top bit of the sum catches
  // the carry out of low. Raw mode just zero-extends low.
  always_comb begin
    e_calc = {1'b0, low_q};
    if (!mode_q) begin
      e_calc = (({1'b0, low_q} + ROUND_MASK) & ~ROUND_MASK) | ROUND_BIT;
    end
  end

  // The flush emits floor(cnt/8) + 1 words, so the final index is the upper
  // bits of cnt, clamped to the number of words the block can hold.
  always_comb begin
    words_m1 = cnt_q[D_SIZE-1:3];
    last_idx = 2'(words_m1);
    if (words_m1 > MAX_IDX_WIDE) begin
      last_idx = MAX_IDX;
    end
  end

  // Handshake qualifiers. in_ready is high only in IDLE and out_valid only in
  // EMIT, so these already ignore requests and acks in the wrong state.
  always_comb begin
    accept    = in_valid & in_ready;
    cnt_bad   = in_cnt > CNT_MAX;
    handshake = out_valid & out_ready;
  end

  // Next-state and next-output logic. Every output is recomputed here and
  // registered below. A word that waits on backpressure keeps its registered
  // value unchanged, because the defaults hold the current outputs.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid;
    out_word_d  = out_word;
    out_index_d = out_index;
    out_last_d  = out_last;
    out_error_d = 1'b0;
    load_in     = 1'b0;
    load_e      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load_in = 1'b1;
          if (cnt_bad) begin
            out_error_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        load_e      = 1'b1;
        state_d     = EMIT;
        out_valid_d = 1'b1;
        out_word_d  = word_at(e_calc, cnt_q, 2'd0);
        out_index_d = 2'd0;
        out_last_d  = (last_idx == 2'd0);
      end

      EMIT: begin
        if (handshake) begin
          if (out_last) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_word_d  = '0;
            out_index_d = 2'd0;
            out_last_d  = 1'b0;
          end else begin
            out_index_d = out_index + 2'd1;
            out_word_d  = word_at(e_q, cnt_q, out_index_d);
            out_last_d  = (out_index_d == last_idx);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_word_d  = '0;
        out_index_d = 2'd0;
        out_last_d  = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State register. Reset aborts any flush in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers. in_ready resets high because the block comes up idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_index <= 2'd0;
      out_last  <= 1'b0;
      out_error <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_word  <= out_word_d;
      out_index <= out_index_d;
      out_last  <= out_last_d;
      out_error <= out_error_d;
    end
  end

  // Datapath registers load only on an accepted request or during CALC, so
  // they stay quiet while the block idles or streams words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      e_q    <= '0;
    end else begin
      if (load_in) begin
        low_q  <= in_low;
        cnt_q  <= in_cnt;
        mode_q <= in_mode;
      end
      if (load_e) begin
        e_q <= e_calc;
      end
    end
  end

endmodule

// File: doc/final_bits_flusher.md
# final_bits_flusher

Sequential, parametrised successor to the combinational final-bits generator at the end of the encoder pipeline. On a flush request it captures the final `low`/`cnt` pair and applies end-of-frame rounding (or passes `low` through raw). It then serialises 1..MAX_WORDS output words toward carry propagation over a valid/ready handshake. This replaces the fixed two-word output with a cnt-dependent word count and supports backpressure.

## Interface
- `OUTPUT_BITSTREAM_WIDTH`, 16: output word width; must be ≥ 8.
- `D_SIZE`, 5: width of `in_cnt`.
- `LOW_WIDTH`, 24: width of `in_low`. The internal `e` register is LOW_WIDTH+1 bits.
- `ROUND_BITS`, 14: rounding mask `M = 2^ROUND_BITS − 1`; must be < LOW_WIDTH.
- `MAX_WORDS`, 3: maximum words per flush; equals `(LOW_WIDTH−8)/8 + 1`.
---
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  flush request.
- `in_ready`  out  1  block idle; request accepted when `in_valid & in_ready`.
- `in_low`  in  LOW_WIDTH  final low value.
- `in_cnt`  in  D_SIZE  final count, unsigned.
- `in_mode`  in  1  0 = rounded (AV1 done), 1 = raw (`e = low`).
- `out_valid`  out  1  `out_word` valid.
- `out_ready`  in  1  downstream accepts word.
- `out_word`  out  OUTPUT_BITSTREAM_WIDTH  emitted word.
- `out_index`  out  2  index of the current word, 0-based.
- `out_last`  out  1  current word is the final word of this flush.
- `out_error`  out  1  one-cycle pulse: request rejected, `in_cnt` out of range.

## Operation
- States: IDLE, CALC, EMIT.
- **IDLE**
  - `in_ready` = 1.
  - On accept: latch `cnt`, `mode`, and `low`.
  - If `cnt > LOW_WIDTH−8`: pulse `out_error` in the next cycle, stay in IDLE, emit no words.
  - Otherwise go to CALC.
- **CALC** (one cycle)
  - Rounded mode: `e = ((low + M) & ~M) | (M + 1)`, computed in LOW_WIDTH+1 bits so the carry is kept.
  - Raw mode: `e = {1'b0, low}`.
  - `N = floor(cnt/8) + 1` (1..MAX_WORDS).
  - `idx = 0`. Go to EMIT.
- **EMIT**
  - Word i has shift `sh_i = cnt + 7 − 8i`.
  - Word 0 is `e >> sh_0`, truncated or zero-extended to OUTPUT_BITSTREAM_WIDTH. It may carry bits above bit 7.
  - Words i ≥ 1 are `(e >> sh_i) & 8'hFF`, zero-extended.
  - `out_last = (idx == N−1)`.
  - On `out_valid & out_ready`:
    - If last, go to IDLE.
    - Otherwise increment `idx`.
- **Output holding**
  - `out_word`, `out_index`, and `out_last` stay stable while `out_valid & !out_ready`.
  - `out_valid` never drops without a handshake.
- **Operand isolation**
  - Datapath registers load only on accept or CALC.
  - `out_word` is 0 whenever `out_valid` = 0.
- **Reset values** (applies at any time, including mid-EMIT)
  - State returns to IDLE and any in-progress flush is discarded.
  - `in_ready` = 1.
  - `out_valid`, `out_word`, `out_index`, `out_last`, `out_error` = 0.
  - Internal `e`, `cnt`, `idx` = 0.
- **Simultaneous events**
  - `in_valid` is ignored outside IDLE (`in_ready` = 0).
  - `out_ready` is ignored outside EMIT.

## Timing
- Accept at cycle T. CALC runs at T+1. `out_valid` with word 0 at T+2.
- Each further word appears the cycle after the previous handshake.
- With `out_ready` held high, N words take N cycles (T+2 .. T+N+1).
- `in_ready` returns high in the cycle after the last handshake. Minimum flush-to-flush spacing is N+2 cycles.
- For an out-of-range request, `out_error` is high at T+1 only and `in_ready` stays high throughout.
- All outputs are registered. There is no combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- **Rounded, minimum count.** `low=0x000000`, `cnt=0`, mode 0, `out_ready=1`.
  - Expect `e=0x4000`.
  - One word `0x0080`, with `out_last=1`, `index 0`, at T+2.
- **Two words.** `low=0x123456`, `cnt=8`, mode 0.
  - Expect `e=0x124000`.
  - Words `0x0024`, then `0x0080` (last) on consecutive cycles.
- **Carry out of LOW_WIDTH.** `low=0xFFFFFF`, `cnt=16`, mode 0.
  - Expect `e=0x1004000`.
  - Words `0x0002`, `0x0000`, `0x0080` (last).
  - Then set `cnt=17`: expect an `out_error` pulse at T+1, no `out_valid`, `in_ready` still 1.
- **Raw mode with backpressure.** `low=0x00ABCD`, `cnt=0`, mode 1, `out_ready=0` for 5 cycles.
  - `out_word=0x0157` is held stable with `out_valid=1` until `out_ready` rises.
  - `in_valid` pulses during EMIT are ignored.
- **Reset mid-flush.** Start the `cnt=16` case and assert `reset` after word 1.
  - All outputs clear immediately.
  - After release, `in_ready=1`.
  - A new `cnt=0` flush emits exactly one word.
